spi_slave_rx_tx: RTL and testbench

Byte-oriented SPI responder: the target-side counterpart to the team's SPI master, allowing an FPGA-internal register block to be addressed by an external or on-chip SPI initiator. It samples sck, ss_n and mosi into the clk domain, shifts full-duplex 8-bit frames in all four CPOL/CPHA modes, and exchanges bytes with local logic through a one-deep transmit buffer and a receive strobe.

---
 rtl/spi_slave_rx_tx.sv | 214 +++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: byte-oriented SPI target, all four CPOL/CPHA modes.
// sck, ss_n and mosi are synchronized into clk and edge-detected, then a
// 3-state controller (IDLE/LOAD/ACTIVE) shifts full-duplex 8-bit frames
// MSB first. Local logic feeds a one-deep tx buffer and sees rx_valid pulses.
// Optional feature macro: SPI_SLAVE_UNDERRUN_EN adds a sticky underrun flag
// that records any byte load from an empty tx buffer.
module spi_slave_rx_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic       underrun
`endif
);

  // Synchronizer depth never drops below two flops.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  logic [SS-1:0] sck_sync_q, sck_sync_d;
  logic [SS-1:0] ss_sync_q, ss_sync_d;
  logic [SS-1:0] mosi_sync_q, mosi_sync_d;
  logic          sck_prev_q, sck_prev_d;
  logic          ss_prev_q, ss_prev_d;
  state_t        state_q, state_d;
  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    tx_buf_q, tx_buf_d;
  logic          tx_full_q, tx_full_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic          underrun_q, underrun_d;
`endif

  logic sck_s, ss_s, mosi_s;
  logic lead, trail, sample_e, shift_e, reload;

  assign sck_s  = sck_sync_q[SS-1];
  assign ss_s   = ss_sync_q[SS-1];
  assign mosi_s = mosi_sync_q[SS-1];

  // Next-state logic: synchronizers, edge detect, frame control, buffers.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SS-2:0], sck};
    ss_sync_d   = {ss_sync_q[SS-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SS-2:0], mosi};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d  = underrun_q;
`endif
    reload      = 1'b0;

    // Leading edge leaves the idle polarity, trailing edge returns to it.
    lead     = (state_q == ACTIVE) && (sck_prev_q == cpol_q) && (sck_s != cpol_q);
    trail    = (state_q == ACTIVE) && (sck_prev_q != cpol_q) && (sck_s == cpol_q);
    sample_e = cpha_q ? trail : lead;
    shift_e  = cpha_q ? lead  : trail;

    case (state_q)
      IDLE: begin
        if (ss_prev_q && !ss_s) begin
          state_d    = LOAD;
          cpol_d     = cpol;
          cpha_d     = cpha;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 7'd0;
          reload     = 1'b1;
        end
      end
      LOAD: begin
        state_d = ss_s ? IDLE : ACTIVE;
      end
      default: begin
        if (ss_s) begin
          // Deselect mid-byte drops the partial byte; tx buffer is untouched.
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sample_e) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
              if (cpha_q) reload = 1'b1;
            end
          end
          if (shift_e) begin
            if (!cpha_q && bit_cnt_q == 3'd0) begin
              reload = 1'b1;
            end else if (!(cpha_q && bit_cnt_q == 3'd0)) begin
              // In cpha=1 the first leading edge is skipped: MSB is already out.
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
    endcase

    // A load accepted in the same clk as an empty-buffer reload stays buffered.
    if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_d = 1'b0;
`endif
    end
    if (reload) begin
      tx_shift_d = tx_full_q ? tx_buf_q : 8'h00;
      if (tx_full_q) tx_full_d = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (!tx_full_q) underrun_d = 1'b1;
`endif
    end

    oe_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
    miso_d = oe_d & tx_shift_d[7];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      tx_buf_q    <= 8'd0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q  <= underrun_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = oe_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx acting as an SPI initiator.
// Optional checks for SPI_SLAVE_UNDERRUN_EN are compiled in with the macro.
module tb_spi_slave_rx_tx;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst, sck, ss_n, mosi, cpol, cpha, tx_load;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun;
`endif

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;

  spi_slave_rx_tx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  // Count rx_valid high cycles away from the active edge.
  always @(negedge clk) if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wclk(1);
    tx_load = 1'b0;
    wclk(2);
  endtask

  task automatic ss_start(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    wclk(6);
    ss_n = 1'b0;
    wclk(8);
  endtask

  task automatic ss_stop();
    wclk(H);
    ss_n = 1'b1;
    sck  = cpol;
    wclk(8);
  endtask

  // Clocks nbits of a byte MSB first, capturing miso at the initiator's sample point.
  task automatic xfer(input int nbits, input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        wclk(H);
        mi = {mi[6:0], miso};
        sck = ~cpol;
        wclk(H);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = mo[7-i];
        wclk(H);
        mi = {mi[6:0], miso};
        sck = cpol;
        wclk(H);
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    int         c0;
    rst = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    wclk(4);
    rst = 1'b1;
    wclk(2);

    // Reset state
    chk("rst_miso", 16'(miso), 16'h0);
    chk("rst_oe", 16'(miso_oe), 16'h0);
    chk("rst_tx_ready", 16'(tx_ready), 16'h1);
    chk("rst_rx_data", 16'(rx_data), 16'h00);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);

    // Mode 0: tx 0xA5, rx 0x3C
    load(8'hA5);
    chk("m0_tx_ready_after_load", 16'(tx_ready), 16'h0);
    c0 = rxv_cnt;
    ss_start(1'b0, 1'b0);
    chk("m0_busy", 16'(busy), 16'h1);
    chk("m0_oe", 16'(miso_oe), 16'h1);
    xfer(8, 8'h3C, mi);
    ss_stop();
    chk("m0_miso_byte", 16'(mi), 16'hA5);
    chk("m0_rx_data", 16'(rx_data), 16'h3C);
    chk("m0_rx_valid_pulses", 16'(rxv_cnt - c0), 16'd1);

    // Mode 3: tx 0x81, rx 0x7E
    load(8'h81);
    c0 = rxv_cnt;
    ss_start(1'b1, 1'b1);
    xfer(8, 8'h7E, mi);
    ss_stop();
    chk("m3_miso_byte", 16'(mi), 16'h81);
    chk("m3_rx_data", 16'(rx_data), 16'h7E);
    chk("m3_rx_valid_pulses", 16'(rxv_cnt - c0), 16'd1);

    // Back-to-back mode 0: 0x12 then 0x34, second byte loaded mid-frame
    load(8'h12);
    c0 = rxv_cnt;
    ss_start(1'b0, 1'b0);
    chk("b2b_ready_after_select", 16'(tx_ready), 16'h1);
    load(8'h34);
    chk("b2b_ready_after_load2", 16'(tx_ready), 16'h0);
    xfer(8, 8'hC8, mi);
    chk("b2b_miso_byte1", 16'(mi), 16'h12);
    wclk(6);
    chk("b2b_ready_after_reload1", 16'(tx_ready), 16'h1);
    chk("b2b_rx_data1", 16'(rx_data), 16'hC8);
    xfer(8, 8'h6B, mi);
    chk("b2b_miso_byte2", 16'(mi), 16'h34);
    ss_stop();
    chk("b2b_ready_after_reload2", 16'(tx_ready), 16'h1);
    chk("b2b_rx_data2", 16'(rx_data), 16'h6B);
    chk("b2b_rx_valid_pulses", 16'(rxv_cnt - c0), 16'd2);

    // No tx_load before select: zeros on miso
    ss_start(1'b0, 1'b0);
    xfer(8, 8'h55, mi);
    ss_stop();
    chk("empty_miso_byte", 16'(mi), 16'h00);
    chk("empty_rx_data", 16'(rx_data), 16'h55);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("underrun_set", 16'(underrun), 16'h1);
    load(8'hEE);
    chk("underrun_cleared", 16'(underrun), 16'h0);
    // consume the pending byte so the following partial frame starts empty
    ss_start(1'b0, 1'b0);
    ss_stop();
`endif

    // Deselect after 5 bits, then a full frame
    c0 = rxv_cnt;
    ss_start(1'b0, 1'b0);
    xfer(5, 8'hFF, mi);
    ss_n = 1'b1;
    sck  = 1'b0;
    wclk(8);
    chk("abort_no_rx_valid", 16'(rxv_cnt - c0), 16'd0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_oe", 16'(miso_oe), 16'h0);
    chk("abort_miso", 16'(miso), 16'h0);
    load(8'h5A);
    ss_start(1'b0, 1'b0);
    xfer(8, 8'hC3, mi);
    ss_stop();
    chk("after_abort_miso_byte", 16'(mi), 16'h5A);
    chk("after_abort_rx_data", 16'(rx_data), 16'hC3);
    chk("after_abort_rx_valid_pulses", 16'(rxv_cnt - c0), 16'd1);

    // Reset low at bit 4 of a mode 1 frame
    load(8'h99);
    c0 = rxv_cnt;
    ss_start(1'b0, 1'b1);
    load(8'h66);
    chk("mid_rst_ready_before", 16'(tx_ready), 16'h0);
    xfer(4, 8'hF0, mi);
    rst = 1'b0;
    wclk(1);
    chk("mid_rst_miso", 16'(miso), 16'h0);
    chk("mid_rst_oe", 16'(miso_oe), 16'h0);
    chk("mid_rst_tx_ready", 16'(tx_ready), 16'h1);
    chk("mid_rst_rx_data", 16'(rx_data), 16'h00);
    chk("mid_rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    ss_n = 1'b1;
    sck  = 1'b0;
    wclk(4);
    rst = 1'b1;
    wclk(6);
    chk("mid_rst_no_rx_valid", 16'(rxv_cnt - c0), 16'd0);
    chk("mid_rst_idle_busy", 16'(busy), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
